// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared definitions for the SPI NOR flash responder.
//   - opcode constants for the supported command set
//   - responder state enumeration
//   - status register bit positions and a helper that assembles the byte
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int unsigned ST_WIP_BIT = 0;
  localparam int unsigned ST_WEL_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ_DATA,
    ST_PROG_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  // WIP never asserts: programming completes instantly in this model.
  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s = '0;
    s[ST_WEL_BIT] = wel;
    return s;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-stage synchronizer for the serial pins plus edge pulses.
//   clk, reset      : system clock, synchronous active-low reset
//   sck_in/cs_in/si_in : raw pins, asynchronous to clk
//   sck_rise/sck_fall  : one-cycle pulses on synced sck edges, only while synced cs is low
//   cs_rise/cs_fall    : one-cycle pulses on synced cs edges
//   si_sync            : synced serial data, aligned with the sck pulses
module spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck_in,
  input  logic cs_in,
  input  logic si_in,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic si_sync
);

  logic [STAGES-1:0] sck_pipe_q, sck_pipe_d;
  logic [STAGES-1:0] cs_pipe_q, cs_pipe_d;
  logic [STAGES-1:0] si_pipe_q, si_pipe_d;
  logic              sck_prev_q, sck_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic              sck_s, cs_s;

  assign sck_s   = sck_pipe_q[STAGES-1];
  assign cs_s    = cs_pipe_q[STAGES-1];
  assign si_sync = si_pipe_q[STAGES-1];

  always_comb begin
    sck_pipe_d = (sck_pipe_q << 1) | STAGES'(sck_in);
    cs_pipe_d  = (cs_pipe_q << 1) | STAGES'(cs_in);
    si_pipe_d  = (si_pipe_q << 1) | STAGES'(si_in);
    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;
  end

  // A synced cs high suppresses sck pulses, so a simultaneous cs rise wins.
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // cs history resets to the selected level: a transaction already in
  // progress at reset release never produces a cs_fall and is skipped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_pipe_q <= '0;
      cs_pipe_q  <= '0;
      si_pipe_q  <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      sck_pipe_q <= sck_pipe_d;
      cs_pipe_q  <= cs_pipe_d;
      si_pipe_q  <= si_pipe_d;
      sck_prev_q <= sck_prev_d;
      cs_prev_q  <= cs_prev_d;
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 single-lane NOR flash device model.
//   clk, reset            : system clock, synchronous active-low reset
//   io_sck, io_cs, io_si  : serial pins from the controller (async to clk)
//   io_so, io_so_oe       : serial data out and its pad enable
//   io_mem_addr/re/rdata  : backing-memory read port (rdata one clk after re)
//   io_mem_we/wdata       : backing-memory write port
//   io_status             : status register (bit1 WEL, bit0 WIP = 0)
// Supports READ, PAGE PROGRAM, WREN, WRDI and RDSR.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned SCK_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_sck,
  input  logic        io_cs,
  input  logic        io_si,
  output logic        io_so,
  output logic        io_so_oe,
  output logic [23:0] io_mem_addr,
  output logic        io_mem_re,
  input  logic [7:0]  io_mem_rdata,
  output logic        io_mem_we,
  output logic [7:0]  io_mem_wdata,
  output logic [7:0]  io_status
);

  logic sck_rise, sck_fall, cs_rise, cs_fall, si_s;

  spi_pin_sync #(
    .STAGES(SCK_SYNC_STAGES)
  ) u_pin_sync (
    .clk     (clk),
    .reset   (reset),
    .sck_in  (io_sck),
    .cs_in   (io_cs),
    .si_in   (io_si),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_rise (cs_rise),
    .cs_fall (cs_fall),
    .si_sync (si_s)
  );

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  addr_bit_cnt_q, addr_bit_cnt_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [6:0]  shift_in_q, shift_in_d;
  logic        is_read_q, is_read_d;
  logic [23:0] addr_q, addr_d;
  logic        wel_q, wel_d;
  logic [7:0]  so_shift_q, so_shift_d;
  logic        so_q, so_d;
  logic        so_oe_q, so_oe_d;
  logic [7:0]  rd_buf_q, rd_buf_d;
  logic        re_dly_q, re_dly_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic [7:0]  in_byte;
  logic [23:0] addr_shift;
  logic [7:0]  out_byte;

  assign in_byte    = {shift_in_q, si_s};
  assign addr_shift = {addr_q[22:0], si_s};
  assign out_byte   = (state_q == ST_STATUS) ? status_byte(wel_q) : rd_buf_q;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    addr_bit_cnt_d = addr_bit_cnt_q;
    out_cnt_d      = out_cnt_q;
    shift_in_d     = shift_in_q;
    is_read_d      = is_read_q;
    addr_d         = addr_q;
    wel_d          = wel_q;
    so_shift_d     = so_shift_q;
    so_d           = so_q;
    rd_buf_d       = rd_buf_q;
    re_dly_d       = mem_re_q;
    mem_re_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;

    if (re_dly_q) begin
      rd_buf_d = io_mem_rdata;
    end

    if (cs_rise) begin
      if (state_q == ST_PROG_DATA) begin
        wel_d = 1'b0;
      end
      state_d        = ST_IDLE;
      bit_cnt_d      = '0;
      addr_bit_cnt_d = '0;
      out_cnt_d      = '0;
    end else if (cs_fall) begin
      state_d        = ST_CMD;
      bit_cnt_d      = '0;
      addr_bit_cnt_d = '0;
      out_cnt_d      = '0;
    end else begin
      if (sck_rise) begin
        case (state_q)
          ST_CMD: begin
            shift_in_d = in_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (in_byte)
                OP_READ: begin state_d = ST_ADDR;   is_read_d = 1'b1; end
                OP_PP:   begin state_d = ST_ADDR;   is_read_d = 1'b0; end
                OP_RDSR: begin state_d = ST_STATUS; end
                OP_WREN: begin state_d = ST_IGNORE; wel_d = 1'b1; end
                OP_WRDI: begin state_d = ST_IGNORE; wel_d = 1'b0; end
                default: begin state_d = ST_IGNORE; end
              endcase
            end
          end
          ST_ADDR: begin
            addr_d         = addr_shift;
            addr_bit_cnt_d = addr_bit_cnt_q + 5'd1;
            if (addr_bit_cnt_q == 5'd23) begin
              addr_bit_cnt_d = '0;
              if (is_read_q) begin
                state_d    = ST_READ_DATA;
                mem_re_d   = 1'b1;
                mem_addr_d = addr_shift;
              end else begin
                state_d = ST_PROG_DATA;
              end
            end
          end
          ST_READ_DATA: begin
            // addr_q always names the byte most recently fetched; the next
            // one is requested during the first bit of the current byte.
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
              addr_d     = addr_q + 24'd1;
              mem_re_d   = 1'b1;
              mem_addr_d = addr_q + 24'd1;
            end
          end
          ST_PROG_DATA: begin
            shift_in_d = in_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (wel_q) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = in_byte;
              end
              addr_d[7:0] = addr_q[7:0] + 8'd1;
            end
          end
          default: begin
          end
        endcase
      end

      // Each byte boundary on the output side reloads the shifter from the
      // prefetch buffer (or the status register), presenting its MSB at once.
      if (sck_fall && (state_q == ST_READ_DATA || state_q == ST_STATUS)) begin
        out_cnt_d = out_cnt_q + 3'd1;
        if (out_cnt_q == 3'd0) begin
          so_d       = out_byte[7];
          so_shift_d = {out_byte[6:0], 1'b0};
        end else begin
          so_d       = so_shift_q[7];
          so_shift_d = {so_shift_q[6:0], 1'b0};
        end
      end
    end

    so_oe_d = (state_d == ST_READ_DATA) || (state_d == ST_STATUS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      addr_bit_cnt_q <= '0;
      out_cnt_q      <= '0;
      shift_in_q     <= '0;
      is_read_q      <= 1'b0;
      addr_q         <= '0;
      wel_q          <= 1'b0;
      so_shift_q     <= '0;
      so_q           <= 1'b0;
      so_oe_q        <= 1'b0;
      rd_buf_q       <= '0;
      re_dly_q       <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      addr_bit_cnt_q <= addr_bit_cnt_d;
      out_cnt_q      <= out_cnt_d;
      shift_in_q     <= shift_in_d;
      is_read_q      <= is_read_d;
      addr_q         <= addr_d;
      wel_q          <= wel_d;
      so_shift_q     <= so_shift_d;
      so_q           <= so_d;
      so_oe_q        <= so_oe_d;
      rd_buf_q       <= rd_buf_d;
      re_dly_q       <= re_dly_d;
      mem_re_q       <= mem_re_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign io_so        = so_q;
  assign io_so_oe     = so_oe_q;
  assign io_mem_addr  = mem_addr_q;
  assign io_mem_re    = mem_re_q;
  assign io_mem_we    = mem_we_q;
  assign io_mem_wdata = mem_wdata_q;
  assign io_status    = status_byte(wel_q);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Testbench for spi_flash_responder: directed plan followed by random
// transactions, with expected memory strobes and SO bytes queued by the
// stimulus side and consumed by an independent monitor.
module tb_spi_flash_responder;

  localparam int unsigned STAGES = 2;
  localparam int unsigned HALF   = STAGES + 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_sck, io_cs, io_si;
  logic        io_so, io_so_oe;
  logic [23:0] io_mem_addr;
  logic        io_mem_re, io_mem_we;
  logic [7:0]  io_mem_rdata = 8'h00;
  logic [7:0]  io_mem_wdata, io_status;

  always #5 clk = ~clk;

  spi_flash_responder #(
    .SCK_SYNC_STAGES(STAGES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_sck      (io_sck),
    .io_cs       (io_cs),
    .io_si       (io_si),
    .io_so       (io_so),
    .io_so_oe    (io_so_oe),
    .io_mem_addr (io_mem_addr),
    .io_mem_re   (io_mem_re),
    .io_mem_rdata(io_mem_rdata),
    .io_mem_we   (io_mem_we),
    .io_mem_wdata(io_mem_wdata),
    .io_status   (io_status)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  dut_mem [logic [23:0]];
  logic [7:0]  ref_mem [logic [23:0]];
  logic        ref_wel = 1'b0;
  logic [23:0] exp_re_q [$];
  logic [31:0] exp_we_q [$];
  logic [7:0]  exp_so_q [$];
  logic [7:0]  tx [$];
  logic [7:0]  pp_data [$];
  int unsigned oe_cycles = 0;

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h, required no event", name, act);
  endtask

  // Backing memory seen by the DUT
  always @(posedge clk) begin
    if (io_mem_re)
      io_mem_rdata <= dut_mem.exists(io_mem_addr) ? dut_mem[io_mem_addr] : dflt(io_mem_addr);
    if (io_mem_we)
      dut_mem[io_mem_addr] = io_mem_wdata;
  end

  // Monitor: consumes expected strobes and SO bytes as the DUT produces them
  logic [7:0]  so_acc = 8'h00;
  int unsigned so_bits = 0;
  logic        sck_prev = 1'b0;
  logic        re_prev = 1'b0, we_prev = 1'b0;

  always @(negedge clk) begin
    if (io_so_oe) oe_cycles++;
    if (io_mem_re) begin
      check("re_we_exclusive", {31'd0, io_mem_we}, 32'd0);
      check("re_width", {31'd0, re_prev}, 32'd0);
      if (exp_re_q.size() == 0) unexpected("unexpected_re", {8'h00, io_mem_addr});
      else check("re_addr", {8'h00, io_mem_addr}, {8'h00, exp_re_q.pop_front()});
    end
    if (io_mem_we) begin
      logic [31:0] e;
      check("we_width", {31'd0, we_prev}, 32'd0);
      if (exp_we_q.size() == 0) unexpected("unexpected_we", {io_mem_addr, io_mem_wdata});
      else begin
        e = exp_we_q.pop_front();
        check("we_addr", {8'h00, io_mem_addr}, {8'h00, e[31:8]});
        check("we_data", {24'h0, io_mem_wdata}, {24'h0, e[7:0]});
      end
    end
    if (io_cs) begin
      so_bits = 0;
    end else if (io_sck && !sck_prev && io_so_oe) begin
      so_acc = {so_acc[6:0], io_so};
      so_bits++;
      if (so_bits == 8) begin
        so_bits = 0;
        if (exp_so_q.size() == 0) unexpected("unexpected_so", {24'h0, so_acc});
        else check("so_byte", {24'h0, so_acc}, {24'h0, exp_so_q.pop_front()});
      end
    end
    sck_prev = io_sck;
    re_prev  = io_mem_re;
    we_prev  = io_mem_we;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Clocks nbits out of tx (zero-padded), optionally pulsing reset before bit rst_at
  task automatic xfer(input int unsigned nbits, input int unsigned rst_at = 32'hFFFF_FFFF);
    io_cs = 1'b0;
    tick(HALF);
    for (int unsigned i = 0; i < nbits; i++) begin
      logic [7:0] b;
      if (i == rst_at) begin
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
      end
      b = (i / 8 < tx.size()) ? tx[i / 8] : 8'h00;
      io_si = b[7 - (i % 8)];
      tick(HALF);
      io_sck = 1'b1;
      tick(HALF);
      io_sck = 1'b0;
    end
    tick(HALF);
    io_cs = 1'b1;
    tick(3 * HALF);
  endtask

  task automatic do_wren();
    tx.delete(); tx.push_back(8'h06);
    xfer(8);
    ref_wel = 1'b1;
  endtask

  task automatic do_wrdi();
    tx.delete(); tx.push_back(8'h04);
    xfer(8);
    ref_wel = 1'b0;
  endtask

  task automatic do_rdsr(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_so_q.push_back({6'b0, ref_wel, 1'b0});
    tx.delete(); tx.push_back(8'h05);
    xfer(8 + 8 * n);
  endtask

  // n data bytes clocked; the device fetches one byte ahead, so n+1 reads
  task automatic do_read(input logic [23:0] a, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_so_q.push_back(ref_rd(24'(a + i)));
    for (int unsigned i = 0; i <= n; i++) exp_re_q.push_back(24'(a + i));
    tx.delete();
    tx.push_back(8'h03); tx.push_back(a[23:16]); tx.push_back(a[15:8]); tx.push_back(a[7:0]);
    xfer(32 + 8 * n);
  endtask

  task automatic do_pp(input logic [23:0] a);
    tx.delete();
    tx.push_back(8'h02); tx.push_back(a[23:16]); tx.push_back(a[15:8]); tx.push_back(a[7:0]);
    for (int unsigned i = 0; i < pp_data.size(); i++) begin
      logic [23:0] wa;
      wa = {a[23:8], 8'(a[7:0] + i)};
      tx.push_back(pp_data[i]);
      if (ref_wel) begin
        exp_we_q.push_back({wa, pp_data[i]});
        ref_mem[wa] = pp_data[i];
      end
    end
    xfer(32 + 8 * pp_data.size());
    ref_wel = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, required completion before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned oe0;
    reset = 1'b0; io_cs = 1'b1; io_sck = 1'b0; io_si = 1'b0;
    dut_mem[24'h000010] = 8'hA5; ref_mem[24'h000010] = 8'hA5;
    dut_mem[24'h000011] = 8'h5A; ref_mem[24'h000011] = 8'h5A;
    tick(5);
    @(negedge clk);
    check("rst_so",     {31'd0, io_so},     32'd0);
    check("rst_so_oe",  {31'd0, io_so_oe},  32'd0);
    check("rst_re",     {31'd0, io_mem_re}, 32'd0);
    check("rst_we",     {31'd0, io_mem_we}, 32'd0);
    check("rst_addr",   {8'h0, io_mem_addr},  32'd0);
    check("rst_wdata",  {24'h0, io_mem_wdata}, 32'd0);
    check("rst_status", {24'h0, io_status},    32'd0);
    tick(1);
    reset = 1'b1;
    tick(4 * HALF);

    do_wren();
    check("status_after_wren", {24'h0, io_status}, 32'h02);
    do_rdsr(2);
    do_wrdi();
    do_rdsr(1);

    do_read(24'h000010, 2);
    do_read(24'hFFFFFF, 2);

    do_wren();
    pp_data.delete(); pp_data.push_back(8'h11); pp_data.push_back(8'h22); pp_data.push_back(8'h33);
    do_pp(24'h0000FE);
    do_rdsr(1);
    do_read(24'h0000FE, 2);
    do_read(24'h000000, 1);

    oe0 = oe_cycles;
    pp_data.delete(); pp_data.push_back(8'h44);
    do_pp(24'h000020);
    check("pp_no_wren_oe", oe_cycles - oe0, 32'd0);
    do_read(24'h000020, 1);

    tx.delete(); tx.push_back(8'h03); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h10);
    xfer(20);
    do_read(24'h000010, 1);

    oe0 = oe_cycles;
    tx.delete(); tx.push_back(8'h9F);
    xfer(32);
    check("unknown_op_oe", oe_cycles - oe0, 32'd0);

    do_wren();
    oe0 = oe_cycles;
    tx.delete(); tx.push_back(8'h03); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h10);
    xfer(48, 10);
    ref_wel = 1'b0;
    check("mid_reset_oe", oe_cycles - oe0, 32'd0);
    check("mid_reset_status", {24'h0, io_status}, 32'h00);
    do_rdsr(1);

    for (int unsigned t = 0; t < 30; t++) begin
      logic [23:0] a;
      case ($urandom_range(0, 4))
        0: do_wren();
        1: do_wrdi();
        2: do_rdsr($urandom_range(1, 3));
        3: begin
          case ($urandom_range(0, 2))
            0: a = 24'hFFFFFF - 24'($urandom_range(0, 2));
            1: a = 24'h000010;
            default: a = 24'($urandom);
          endcase
          do_read(a, $urandom_range(1, 4));
        end
        default: begin
          a = 24'($urandom);
          if ($urandom_range(0, 1) == 1) a[7:0] = 8'hFF - 8'($urandom_range(0, 2));
          pp_data.delete();
          for (int unsigned k = 0; k < $urandom_range(1, 4); k++) pp_data.push_back(8'($urandom));
          do_pp(a);
          do_read(a, 2);
        end
      endcase
    end

    tick(4 * HALF);
    check("re_queue_drained", exp_re_q.size(), 32'd0);
    check("we_queue_drained", exp_we_q.size(), 32'd0);
    check("so_queue_drained", exp_so_q.size(), 32'd0);
    check("final_status", {24'h0, io_status}, {24'h0, 6'b0, ref_wel, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI-mode-0 target that emulates a single-lane serial NOR flash device on the far end of the flash controller's `io_cs`/`io_SI`/serial-clock pins. It decodes READ, PAGE PROGRAM, WREN, WRDI and RDSR from the serial stream and services them against a byte-wide backing-memory port. It serves as the device-side model in system simulation and FPGA loopback tests. Quad I/O is out of scope.

## Interface
- `SCK_SYNC_STAGES`, default 2: synchronizer depth on `io_sck`/`io_cs`/`io_si`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `io_sck`  in  1  serial clock from the controller; asynchronous to `clk`.
- `io_cs`  in  1  chip select, active low.
- `io_si`  in  1  serial data in, MSB first.
- `io_so`  out  1  serial data out, MSB first.
- `io_so_oe`  out  1  output enable for `io_so`; a pad wrapper drives Z when low.
- `io_mem_addr`  out  24  backing-memory byte address.
- `io_mem_re`  out  1  one-cycle read strobe.
- `io_mem_rdata`  in  8  read data, valid exactly 1 `clk` after `io_mem_re`.
- `io_mem_we`  out  1  one-cycle write strobe.
- `io_mem_wdata`  out  8  write data.
- `io_status`  out  8  current status register (bit1 WEL, bit0 WIP fixed 0, others 0).

## Operation
- `io_sck`, `io_cs` and `io_si` pass through the sync stages. Rise/fall pulses come from the synced `io_sck` and are qualified by synced `io_cs` low.
- SI is sampled on sck rise. SO shifts on sck fall. The first SO bit is presented on the first fall after the last command/address bit.
- States:
  - IDLE: `io_cs` falls -> CMD.
  - CMD: 8 bits collected, then by opcode:
    - 0x03 -> ADDR
    - 0x02 -> ADDR
    - 0x05 -> STATUS
    - 0x06 -> WEL=1 -> IGNORE
    - 0x04 -> WEL=0 -> IGNORE
    - other -> IGNORE
  - ADDR: 24 bits, MSB first. Then READ_DATA for 0x03, or PROG_DATA for 0x02.
  - READ_DATA: `io_mem_re` pulses on the `clk` after the last address bit is sampled. The byte is loaded into the out-shifter. Subsequent bytes are prefetched on the rise of bit 7 of the current byte. Address increments by 1 per byte and wraps 0xFFFFFF -> 0x000000.
  - PROG_DATA: each completed byte produces one `io_mem_we` pulse with the current address, but only if WEL=1. Only `addr[7:0]` increments, so the address wraps within the 256-byte page.
  - STATUS: shifts `io_status` repeatedly while selected.
  - IGNORE: SO disabled, input discarded.
- `io_cs` rising (synced) in any state:
  - return to IDLE and clear the bit counter; any partial byte is discarded, with no memory write.
  - WEL clears if the transaction was a PAGE PROGRAM that reached PROG_DATA.
- `io_so_oe`=1 only in READ_DATA and STATUS while `io_cs` is low.
- Counters: 3-bit bit counter; 5-bit address-bit counter (0..23).

## Timing
- Reset (`reset`=0 at a clk edge): state IDLE, WEL=0, `io_so`=0, `io_so_oe`=0, `io_mem_re`=0, `io_mem_we`=0, `io_mem_addr`=0, `io_mem_wdata`=0, `io_status`=0.
- Reset mid-transaction aborts it with no memory strobe. The responder then waits for the next `io_cs` fall; a transaction already in progress (CS still low) is not picked up.
- Required sck: each sck high and low phase ≥ `SCK_SYNC_STAGES`+3 `clk` cycles, so read data is loaded before the next fall.
- `io_mem_re`/`io_mem_we` are exactly 1 cycle wide, never asserted together, at most one per byte.
- A write strobe fires `SCK_SYNC_STAGES`+1 `clk` cycles after the raw sck rise carrying bit 0 of a data byte.
- Simultaneous CS rise and sck rise in the same synced cycle: CS wins; the edge is not counted.

## Structure
- Package `spi_flash_pkg`:
  - opcode constants `OP_READ`=0x03, `OP_PP`=0x02, `OP_WREN`=0x06, `OP_WRDI`=0x04, `OP_RDSR`=0x05
  - state enum (IDLE, CMD, ADDR, READ_DATA, PROG_DATA, STATUS, IGNORE)
  - status bit indices
- One sub-module `spi_pin_sync`: N-stage synchronizer for sck/cs/si plus rise/fall pulse generation.

## Test plan
- WREN (0x06), CS high, then RDSR (0x05) -> SO returns 0x02 twice while clocked 16 bits; WRDI then RDSR -> 0x00.
- Memory holds 0xA5,0x5A at 0x000010/11; READ 0x03 00 00 10, 16 clocks -> SO 0xA5 then 0x5A, `io_mem_addr` 0x10 then 0x11.
- READ at 0xFFFFFF, 2 bytes -> `io_mem_re` addresses 0xFFFFFF then 0x000000.
- WREN, then PP 0x02 00 00 FE with data 0x11,0x22,0x33 -> writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33); RDSR afterwards -> 0x00.
- PP without WREN -> no `io_mem_we`; `io_so_oe` stays 0 throughout.
- CS raised after 12 address bits, then READ of 0x000010 -> abort leaves no strobes; next transaction returns 0xA5 correctly; unknown opcode 0x9F -> SO stays disabled.
